mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 142 ++++++++++++++
 tb/tb_mult_div_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative radix-2 multiply/divide unit with Hi/Lo result registers.
// One iteration per cycle on operand magnitudes; signs are fixed up in a final cycle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             HiWrite,
    input  logic             LoWrite,
    input  logic [WIDTH-1:0] WriteData,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               busy_q, busy_d, done_q, done_d, dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic [WIDTH-1:0]   in_a_mag, in_b_mag, a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, div_rem, div_diff;
    logic [2*WIDTH-1:0] mul_step, div_step, prod;
    logic               neg_q, neg_r;

    always_comb begin
        in_a_mag = (!Op[0] && A[WIDTH-1]) ? -A : A;
        in_b_mag = (!Op[0] && B[WIDTH-1]) ? -B : B;
        a_mag    = (!op_q[0] && a_q[WIDTH-1]) ? -a_q : a_q;
        b_mag    = (!op_q[0] && b_q[WIDTH-1]) ? -b_q : b_q;
        // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, shift right.
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_mag} : '0);
        mul_step = {mul_sum, acc_q[WIDTH-1:1]};
        // Divide: acc = {remainder, quotient}; shift left, trial-subtract divisor.
        div_rem  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff = div_rem - {1'b0, b_mag};
        div_step = div_diff[WIDTH] ? {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                   : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        neg_q    = !op_q[0] && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        neg_r    = !op_q[0] && a_q[WIDTH-1];
        prod     = neg_q ? -acc_q : acc_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    op_d    = Op;
                    a_d     = A;
                    b_d     = B;
                    acc_d   = {{WIDTH{1'b0}}, Op[1] ? in_a_mag : in_b_mag};
                    busy_d  = 1'b1;
                    dz_d    = 1'b0;
                end else begin
                    hi_d = HiWrite ? WriteData : hi_q;
                    lo_d = LoWrite ? WriteData : lo_q;
                end
            end
            RUN: begin
                acc_d   = op_q[1] ? div_step : mul_step;
                cnt_d   = cnt_q + CW'(1);
                state_d = (cnt_q == CW'(WIDTH - 1)) ? FIX : RUN;
            end
            FIX: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (!op_q[1]) begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else if (b_q == '0) begin
                    dz_d = 1'b1;
                    hi_d = a_q;
                    lo_d = '1;
                end else begin
                    hi_d = neg_r ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                    lo_d = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign Busy    = busy_q;
    assign Done    = done_q;
    assign DivZero = dz_q;
    assign Hi      = hi_q;
    assign Lo      = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed and randomized checks of mult_div_unit against an arithmetic model.
module tb_mult_div_unit;
    logic        Clk, Reset, Start, HiWrite, LoWrite;
    logic [1:0]  Op;
    logic [31:0] A, B, WriteData;
    logic        Busy, Done, DivZero;
    logic [31:0] Hi, Lo;
    int          vectors = 0, miscompares = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
        .HiWrite(HiWrite), .LoWrite(LoWrite), .WriteData(WriteData),
        .Busy(Busy), .Done(Done), .DivZero(DivZero), .Hi(Hi), .Lo(Lo)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference: full-width integer arithmetic; / and % truncate toward zero.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, b,
                                  output logic [31:0] hi, lo, output logic dz);
        logic [63:0] ea, eb, p;
        longint      sa, sb, q, r;
        ea = op[0] ? {32'b0, a} : {{32{a[31]}}, a};
        eb = op[0] ? {32'b0, b} : {{32{b[31]}}, b};
        dz = 1'b0;
        if (!op[1]) begin
            p  = ea * eb;
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'd0) begin
            dz = 1'b1;
            hi = a;
            lo = 32'hFFFFFFFF;
        end else begin
            sa = longint'(ea);
            sb = longint'(eb);
            q  = sa / sb;
            r  = sa % sb;
            lo = q[31:0];
            hi = r[31:0];
        end
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom % 7)
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'h7FFFFFFF;
            4: return 32'($urandom % 16);
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge of the Done cycle so a caller may start back-to-back.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, b, input logic wr, input int inj);
        logic [31:0] eh, el, hp, lp;
        logic        edz, done_busy;
        int          n;
        bit          got, stable;
        model(op, a, b, eh, el, edz);
        hp = Hi; lp = Lo; stable = 1; n = 0; got = 0; done_busy = 1'b1;
        Start = 1; Op = op; A = a; B = b; HiWrite = wr; LoWrite = wr; WriteData = $urandom;
        @(posedge Clk); #1;
        Start = 0; HiWrite = 0; LoWrite = 0; A = $urandom; B = $urandom; Op = 2'($urandom);
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge Clk);
            if (i == 0) begin
                vectors++;
                if (DivZero !== 1'b0) begin miscompares++; $display("FAIL dz_clear: DivZero=%b want 0", DivZero); end
            end
            if (i == inj) begin Start = 1; HiWrite = 1; LoWrite = 1; WriteData = 32'h12345678; end
            else if (i == inj + 1) begin Start = 0; HiWrite = 0; LoWrite = 0; end
            if (Done === 1'b1) begin got = 1; done_busy = Busy; end
            else begin
                if (Busy === 1'b1) n++;
                if (Hi !== hp || Lo !== lp) stable = 0;
            end
        end
        vectors++;
        if (!got) begin miscompares++; $display("FAIL done_timeout: op=%0d no Done within 100 cycles", op); end
        vectors++;
        if (n != 33) begin miscompares++; $display("FAIL busy_len: op=%0d busy=%0d want 33", op, n); end
        vectors++;
        if (done_busy !== 1'b0) begin miscompares++; $display("FAIL busy_in_done: Busy=%b want 0", done_busy); end
        vectors++;
        if (!stable) begin miscompares++; $display("FAIL hilo_hold: Hi/Lo changed while busy, was %h/%h", hp, lp); end
        vectors++;
        if (Hi !== eh || Lo !== el || DivZero !== edz)
            begin miscompares++; $display("FAIL result: op=%0d a=%h b=%h got Hi=%h Lo=%h dz=%b want Hi=%h Lo=%h dz=%b",
                                          op, a, b, Hi, Lo, DivZero, eh, el, edz); end
    endtask

    task automatic gap();
        @(negedge Clk);
        vectors++;
        if (Done !== 1'b0 || Busy !== 1'b0) begin miscompares++; $display("FAIL done_pulse: Done=%b Busy=%b want 0/0", Done, Busy); end
    endtask

    task automatic test_reset();
        Reset = 1; Start = 0; HiWrite = 0; LoWrite = 0; Op = 0; A = 0; B = 0; WriteData = 0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        vectors++;
        if (Busy !== 0 || Done !== 0 || DivZero !== 0 || Hi !== 0 || Lo !== 0)
            begin miscompares++; $display("FAIL reset: Busy=%b Done=%b dz=%b Hi=%h Lo=%h want all 0", Busy, Done, DivZero, Hi, Lo); end
        Reset = 0;
    endtask

    task automatic test_writes();
        logic [31:0] d1, d2, d3;
        d1 = $urandom; d2 = $urandom; d3 = $urandom;
        HiWrite = 1; WriteData = d1; @(negedge Clk); HiWrite = 0;
        vectors++;
        if (Hi !== d1 || Lo !== 0) begin miscompares++; $display("FAIL mthi: Hi=%h Lo=%h want %h/0", Hi, Lo, d1); end
        LoWrite = 1; WriteData = d2; @(negedge Clk); LoWrite = 0;
        vectors++;
        if (Hi !== d1 || Lo !== d2) begin miscompares++; $display("FAIL mtlo: Hi=%h Lo=%h want %h/%h", Hi, Lo, d1, d2); end
        HiWrite = 1; LoWrite = 1; WriteData = d3; @(negedge Clk); HiWrite = 0; LoWrite = 0;
        vectors++;
        if (Hi !== d3 || Lo !== d3) begin miscompares++; $display("FAIL mthilo: Hi=%h Lo=%h want %h/%h", Hi, Lo, d3, d3); end
    endtask

    task automatic test_directed();
        run_op(2'b00, 32'hFFFFFFFD, 32'h00000005, 1'b0, -1); gap();
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, -1);
        run_op(2'b11, 32'h00000064, 32'h00000007, 1'b0, -1); gap();
        run_op(2'b10, 32'hFFFFFFF9, 32'h00000002, 1'b0, -1); gap();
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, -1); gap();
        run_op(2'b11, 32'h00000064, 32'h00000000, 1'b0, -1);
        run_op(2'b10, 32'hFFFFFF9C, 32'h00000000, 1'b0, -1);
        run_op(2'b00, 32'h00000003, 32'h00000007, 1'b0, -1); gap();
    endtask

    task automatic test_ignored();
        run_op(2'b00, 32'h00001234, 32'hFFFF0001, 1'b0, 5); gap();
        run_op(2'b10, 32'h7FFFFFFF, 32'hFFFFFFFD, 1'b1, -1); gap();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 40; k++) begin
            run_op(2'($urandom), pick(), pick(), 1'($urandom), ($urandom % 4 == 0) ? int'($urandom % 30) : -1);
            if ($urandom % 2) gap();
        end
        gap();
    endtask

    task automatic test_abort();
        int dn;
        HiWrite = 1; LoWrite = 1; WriteData = 32'hA5A5A5A5; @(negedge Clk); HiWrite = 0; LoWrite = 0;
        Start = 1; Op = 2'b10; A = $urandom; B = $urandom | 32'h1;
        @(posedge Clk); #1 Start = 0;
        repeat (10) @(negedge Clk);
        Reset = 1; @(posedge Clk); #1 Reset = 0;
        @(negedge Clk);
        vectors++;
        if (Busy !== 0 || Hi !== 0 || Lo !== 0 || DivZero !== 0)
            begin miscompares++; $display("FAIL abort: Busy=%b Hi=%h Lo=%h dz=%b want 0", Busy, Hi, Lo, DivZero); end
        dn = 0;
        for (int i = 0; i < 40; i++) begin @(negedge Clk); if (Done !== 1'b0 || Hi !== 0 || Lo !== 0) dn++; end
        vectors++;
        if (dn != 0) begin miscompares++; $display("FAIL abort_quiet: %0d cycles with Done or Hi/Lo change, want 0", dn); end
        Reset = 1; Start = 1; Op = 2'b01; A = 32'h5; B = 32'h6; HiWrite = 1; LoWrite = 1; WriteData = 32'hDEADBEEF;
        @(posedge Clk); #1 Reset = 0; Start = 0; HiWrite = 0; LoWrite = 0;
        dn = 0;
        for (int i = 0; i < 40; i++) begin @(negedge Clk); if (Busy !== 1'b0 || Done !== 1'b0 || Hi !== 0 || Lo !== 0) dn++; end
        vectors++;
        if (dn != 0) begin miscompares++; $display("FAIL reset_priority: %0d cycles busy/done/written, want 0", dn); end
    endtask

    initial begin
        test_reset();
        test_writes();
        test_directed();
        test_ignored();
        test_back_to_back();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
